// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, write-back control bit positions and vector-port source encoding
// for the write-back port arbiter.
package wb_port_arbiter_pkg;

  localparam int LENGTH = 8;
  localparam int INT8   = 8;
  localparam int INT32  = 32;
  localparam int VW     = LENGTH * INT8;

  localparam int WB_SCALAR = 0;
  localparam int WB_VECTOR = 1;

  typedef enum logic [1:0] {
    VSEL_NONE,
    VSEL_PIPE,
    VSEL_FIFO,
    VSEL_BYPASS
  } vsel_e;

endpackage

// File: rtl/wb_port_arbiter_conv_wb_fifo.sv
// Synchronous FIFO of pending convolution writes {addr, data}, with a per-entry
// destination compare used by decode to detect hazards on pending writes.
module conv_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [AW-1:0]              waddr_i,
  input  logic [DW-1:0]              wdata_i,
  output logic [AW-1:0]              head_addr_o,
  output logic [DW-1:0]              head_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o,
  input  logic [AW-1:0]              q_addr_i,
  output logic                       q_match_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;
  logic [PW-1:0] offset;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CW'(DEPTH));
  assign push_ok     = push_i && !full_o;
  assign pop_ok      = pop_i && !empty_o;
  assign head_addr_o = addr_mem[rd_ptr_q];
  assign head_data_o = data_mem[rd_ptr_q];
  assign count_o     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: validity comes from the occupancy count alone.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[wr_ptr_q] <= waddr_i;
      data_mem[wr_ptr_q] <= wdata_i;
    end
  end

  always_comb begin
    q_match_o = 1'b0;
    offset    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr_q;
      if (({1'b0, offset} < count_q) && (addr_mem[i] == q_addr_i)) q_match_o = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: registers scalar/vector RF writes from MEM/WB and shares
// the vector port with buffered convolution writes, with anti-starvation bubbles.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int CONV_DEPTH = 4,
  parameter int MAX_WAIT   = 8,
  parameter int AW         = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [VW-1:0]                 conv_result,
  input  logic [AW-1:0]                 conv_addr,
  input  logic                          conv_write,
  output logic                          conv_ready,
  input  logic [AW-1:0]                 rD,
  input  logic [INT32-1:0]              s_result,
  input  logic [VW-1:0]                 v_result,
  input  logic [INT32-1:0]              smem,
  input  logic [VW-1:0]                 vmem,
  input  logic                          ldr,
  input  logic [1:0]                    wb,
  output logic                          s_we,
  output logic [AW-1:0]                 s_waddr,
  output logic [INT32-1:0]              s_wdata,
  output logic                          v_we,
  output logic [AW-1:0]                 v_waddr,
  output logic [VW-1:0]                 v_wdata,
  output logic                          v_src,
  output logic                          bubble_req,
  input  logic [AW-1:0]                 q_addr,
  output logic                          q_hit,
  output logic [$clog2(CONV_DEPTH):0]   fifo_count,
  output logic                          overflow_err
);

  localparam int                WW       = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]     WAIT_MAX = WW'(MAX_WAIT);

  logic [AW-1:0]    head_addr;
  logic [VW-1:0]    head_data;
  logic             fifo_empty, fifo_full, fifo_hit;
  logic             conv_acc, push, pop;
  vsel_e            vsel;

  logic             s_we_q, s_we_d;
  logic [AW-1:0]    s_waddr_q, s_waddr_d;
  logic [INT32-1:0] s_wdata_q, s_wdata_d;
  logic             v_we_q, v_we_d;
  logic [AW-1:0]    v_waddr_q, v_waddr_d;
  logic [VW-1:0]    v_wdata_q, v_wdata_d;
  logic             v_src_q, v_src_d;
  logic             bubble_q, bubble_d;
  logic             overflow_q, overflow_d;
  logic [WW-1:0]    wait_q, wait_d;

  conv_wb_fifo #(
    .DEPTH (CONV_DEPTH),
    .AW    (AW),
    .DW    (VW)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .waddr_i     (conv_addr),
    .wdata_i     (conv_result),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .q_addr_i    (q_addr),
    .q_match_o   (fifo_hit)
  );

  assign conv_ready = !fifo_full;
  assign conv_acc   = conv_write && conv_ready;
  assign q_hit      = fifo_hit || (conv_acc && (conv_addr == q_addr));

  always_comb begin
    vsel = VSEL_NONE;
    if (wb[WB_VECTOR])  vsel = VSEL_PIPE;
    else if (!fifo_empty) vsel = VSEL_FIFO;
    else if (conv_acc)  vsel = VSEL_BYPASS;
  end

  assign pop  = (vsel == VSEL_FIFO);
  assign push = conv_acc && (vsel != VSEL_BYPASS);

  always_comb begin
    s_we_d    = wb[WB_SCALAR];
    s_waddr_d = rD;
    s_wdata_d = ldr ? smem : s_result;

    v_we_d    = 1'b0;
    v_waddr_d = '0;
    v_wdata_d = '0;
    v_src_d   = 1'b0;
    case (vsel)
      VSEL_PIPE: begin
        v_we_d    = 1'b1;
        v_waddr_d = rD;
        v_wdata_d = ldr ? vmem : v_result;
      end
      VSEL_FIFO: begin
        v_we_d    = 1'b1;
        v_waddr_d = head_addr;
        v_wdata_d = head_data;
        v_src_d   = 1'b1;
      end
      VSEL_BYPASS: begin
        v_we_d    = 1'b1;
        v_waddr_d = conv_addr;
        v_wdata_d = conv_result;
        v_src_d   = 1'b1;
      end
      default: ;
    endcase

    overflow_d = overflow_q || (conv_write && !conv_ready);

    // Bubble rises one cycle after the head has waited MAX_WAIT, drops after a pop.
    wait_d   = wait_q;
    bubble_d = bubble_q;
    if (fifo_empty || pop) begin
      wait_d   = '0;
      bubble_d = 1'b0;
    end else begin
      if (wait_q == WAIT_MAX) bubble_d = 1'b1;
      else                    wait_d   = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_we_q     <= 1'b0;
      s_waddr_q  <= '0;
      s_wdata_q  <= '0;
      v_we_q     <= 1'b0;
      v_waddr_q  <= '0;
      v_wdata_q  <= '0;
      v_src_q    <= 1'b0;
      bubble_q   <= 1'b0;
      overflow_q <= 1'b0;
      wait_q     <= '0;
    end else begin
      s_we_q     <= s_we_d;
      s_waddr_q  <= s_waddr_d;
      s_wdata_q  <= s_wdata_d;
      v_we_q     <= v_we_d;
      v_waddr_q  <= v_waddr_d;
      v_wdata_q  <= v_wdata_d;
      v_src_q    <= v_src_d;
      bubble_q   <= bubble_d;
      overflow_q <= overflow_d;
      wait_q     <= wait_d;
    end
  end

  assign s_we         = s_we_q;
  assign s_waddr      = s_waddr_q;
  assign s_wdata      = s_wdata_q;
  assign v_we         = v_we_q;
  assign v_waddr      = v_waddr_q;
  assign v_wdata      = v_wdata_q;
  assign v_src        = v_src_q;
  assign bubble_req   = bubble_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the write-back rules.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXW  = 8;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [VW-1:0]    conv_result;
  logic [AW-1:0]    conv_addr;
  logic             conv_write;
  logic             conv_ready;
  logic [AW-1:0]    rD;
  logic [INT32-1:0] s_result;
  logic [VW-1:0]    v_result;
  logic [INT32-1:0] smem;
  logic [VW-1:0]    vmem;
  logic             ldr;
  logic [1:0]       wb;
  logic             s_we;
  logic [AW-1:0]    s_waddr;
  logic [INT32-1:0] s_wdata;
  logic             v_we;
  logic [AW-1:0]    v_waddr;
  logic [VW-1:0]    v_wdata;
  logic             v_src;
  logic             bubble_req;
  logic [AW-1:0]    q_addr;
  logic             q_hit;
  logic [2:0]       fifo_count;
  logic             overflow_err;

  wb_port_arbiter #(.CONV_DEPTH(DEPTH), .MAX_WAIT(MAXW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .conv_result(conv_result), .conv_addr(conv_addr),
    .conv_write(conv_write), .conv_ready(conv_ready), .rD(rD), .s_result(s_result),
    .v_result(v_result), .smem(smem), .vmem(vmem), .ldr(ldr), .wb(wb),
    .s_we(s_we), .s_waddr(s_waddr), .s_wdata(s_wdata), .v_we(v_we), .v_waddr(v_waddr),
    .v_wdata(v_wdata), .v_src(v_src), .bubble_req(bubble_req), .q_addr(q_addr),
    .q_hit(q_hit), .fifo_count(fifo_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [VW-1:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_wait;
  bit   m_bubble, m_ovf;
  bit   e_s_we, e_v_we, e_v_src;
  logic [AW-1:0]    e_s_waddr, e_v_waddr;
  logic [INT32-1:0] e_s_wdata;
  logic [VW-1:0]    e_v_wdata;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    conv_result = '0; conv_addr = '0; conv_write = 1'b0; rD = '0;
    s_result = '0; v_result = '0; smem = '0; vmem = '0; ldr = 1'b0; wb = 2'b00;
    q_addr = '0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_wait = 0; m_bubble = 0; m_ovf = 0;
  endtask

  // Drive is already applied (just after a falling edge); checks combinational
  // outputs, advances the model, clocks once, checks registered outputs.
  task automatic step();
    int   sz;
    bit   rdy, popped, byp, hit;
    ent_t e;
    #1;
    sz  = mq.size();
    rdy = (sz < DEPTH);
    hit = 0;
    foreach (mq[i]) if (mq[i].addr == q_addr) hit = 1;
    if (conv_write && rdy && conv_addr == q_addr) hit = 1;
    chk("conv_ready", 64'(conv_ready), 64'(rdy));
    chk("q_hit", 64'(q_hit), 64'(hit));
    chk("count_pre", 64'(fifo_count), 64'(sz));

    popped = 0; byp = 0;
    e_s_we = wb[0]; e_s_waddr = rD; e_s_wdata = ldr ? smem : s_result;
    e_v_we = 0; e_v_src = 0; e_v_waddr = '0; e_v_wdata = '0;
    if (wb[1]) begin
      e_v_we = 1; e_v_waddr = rD; e_v_wdata = ldr ? vmem : v_result;
    end else if (sz > 0) begin
      e = mq.pop_front();
      e_v_we = 1; e_v_src = 1; e_v_waddr = e.addr; e_v_wdata = e.data; popped = 1;
    end else if (conv_write && rdy) begin
      e_v_we = 1; e_v_src = 1; e_v_waddr = conv_addr; e_v_wdata = conv_result; byp = 1;
    end
    if (conv_write) begin
      if (!rdy) m_ovf = 1;
      else if (!byp) begin
        e.addr = conv_addr; e.data = conv_result;
        mq.push_back(e);
      end
    end
    if (sz == 0 || popped) begin
      m_wait = 0; m_bubble = 0;
    end else begin
      if (m_wait == MAXW) m_bubble = 1;
      m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
    end

    @(posedge clk);
    #1;
    chk("s_we", 64'(s_we), 64'(e_s_we));
    if (e_s_we) begin
      chk("s_waddr", 64'(s_waddr), 64'(e_s_waddr));
      chk("s_wdata", 64'(s_wdata), 64'(e_s_wdata));
    end
    chk("v_we", 64'(v_we), 64'(e_v_we));
    if (e_v_we) begin
      chk("v_waddr", 64'(v_waddr), 64'(e_v_waddr));
      chk("v_wdata", 64'(v_wdata), 64'(e_v_wdata));
      chk("v_src", 64'(v_src), 64'(e_v_src));
    end
    chk("bubble_req", 64'(bubble_req), 64'(m_bubble));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s"}, {31'd0, s_we, 27'd0, s_waddr}, 64'd0);
    chk({tag, "_sdata"}, 64'(s_wdata), 64'd0);
    chk({tag, "_v"}, {56'd0, v_we, v_src, 1'b0, v_waddr}, 64'd0);
    chk({tag, "_vdata"}, 64'(v_wdata), 64'd0);
    chk({tag, "_flags"}, {61'd0, bubble_req, overflow_err, q_hit}, 64'd0);
    chk({tag, "_count"}, 64'(fifo_count), 64'd0);
  endtask

  initial begin
    int n;
    int pv;
    idle();
    model_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    #1 chk("ready_after_reset", 64'(conv_ready), 64'd1);

    // Scalar path, ALU then load data
    idle(); wb = 2'b01; rD = 5'd3; s_result = 32'h1234;
    step();
    chk("scalar_alu", {s_we, v_we, 27'd0, s_waddr, s_wdata}, {1'b1, 1'b0, 27'd0, 5'd3, 32'h1234});
    idle(); wb = 2'b01; rD = 5'd3; ldr = 1'b1; smem = 32'hBEEF; s_result = 32'h5555;
    step();
    chk("scalar_load", 64'(s_wdata), 64'h0000BEEF);

    // Bypass into an empty FIFO
    idle(); conv_write = 1'b1; conv_addr = 5'd7; conv_result = 64'hA5A5_0707_1234_5678;
    step();
    chk("bypass", {v_we, v_src, v_waddr, 3'(fifo_count)}, {1'b1, 1'b1, 5'd7, 3'd0});

    // Contention: pipeline wins, conv write parks in the FIFO
    idle(); wb = 2'b10; rD = 5'd2; v_result = 64'h0202_0202_0202_0202;
    conv_write = 1'b1; conv_addr = 5'd9; conv_result = 64'h0909_0909_0909_0909;
    step();
    chk("contend_pipe", {v_src, v_waddr, 3'(fifo_count)}, {1'b0, 5'd2, 3'd1});
    idle();
    step();
    chk("contend_conv", {v_src, v_waddr, 3'(fifo_count)}, {1'b1, 5'd9, 3'd0});

    // Fill under continuous pipeline vector writes, then overflow
    for (int i = 0; i < 4; i++) begin
      idle(); wb = 2'b10; rD = 5'd1; conv_write = 1'b1; conv_addr = 5'(10 + i);
      conv_result = 64'(i + 1) * 64'h0101_0101_0101_0101;
      step();
    end
    chk("full", {conv_ready, 3'(fifo_count)}, {1'b0, 3'd4});
    idle(); wb = 2'b10; conv_write = 1'b1; conv_addr = 5'd20;
    step();
    chk("overflow", {overflow_err, 3'(fifo_count)}, {1'b1, 3'd4});

    // Hazard lookup against queued entries
    idle(); wb = 2'b10; q_addr = 5'd12;
    #1 chk("q_hit_12", 64'(q_hit), 64'd1);
    q_addr = 5'd13;
    #1 chk("q_hit_13", 64'(q_hit), 64'd1);
    q_addr = 5'd21;
    #1 chk("q_hit_21", 64'(q_hit), 64'd0);
    idle(); q_addr = 5'd12;
    step();
    chk("pre_reset_count", 64'(fifo_count), 64'd3);

    // Asynchronous reset with three entries queued
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle();
    step();

    // Starvation: one queued entry behind continuous pipeline vector writes
    idle(); wb = 2'b10; conv_write = 1'b1; conv_addr = 5'd4;
    step();
    n = 0;
    while (bubble_req !== 1'b1 && n < 20) begin
      idle(); wb = 2'b10; rD = 5'd6;
      step();
      n++;
    end
    chk("starve_cycles", 64'(n), 64'd9);
    idle();
    step();
    chk("bubble_drop", {v_src, v_waddr, bubble_req}, {1'b1, 5'd4, 1'b0});

    // Random traffic, with phases of varying pipeline vector pressure
    for (int ph = 0; ph < 6; ph++) begin
      pv = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 60 : 95;
      for (int c = 0; c < 120; c++) begin
        conv_write  = ($urandom_range(99) < 55);
        conv_addr   = 5'($urandom_range(15));
        conv_result = {$urandom, $urandom};
        rD          = 5'($urandom_range(31));
        s_result    = $urandom;
        smem        = $urandom;
        v_result    = {$urandom, $urandom};
        vmem        = {$urandom, $urandom};
        ldr         = 1'($urandom_range(1));
        wb          = {($urandom_range(99) < pv), 1'($urandom_range(1))};
        if (mq.size() > 0 && $urandom_range(1) == 1)
          q_addr = mq[$urandom_range(mq.size() - 1)].addr;
        else
          q_addr = 5'($urandom_range(15));
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
